// File: rtl/sklansky_subtractor_pipe_if.sv
// Operand/result handshake bundle for the pipelined Sklansky subtractor.
interface sklansky_subtractor_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_borrow;
    logic             out_zero;
    logic             out_neg;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_bin, out_ready,
        input  in_ready, out_valid, out_diff, out_borrow, out_zero, out_neg, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_bin, out_ready,
        output in_ready, out_valid, out_diff, out_borrow, out_zero, out_neg, out_ovf
    );
endinterface

// File: rtl/sklansky_subtractor_pipe.sv
// Two-stage a - b - bin subtractor; Sklansky borrow-prefix levels split across the stages.
module sklansky_subtractor_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SPLIT = 3
) (
    input logic                       clk,
    input logic                       rst,
    sklansky_subtractor_pipe_if.slave bus
);
    localparam int unsigned LEVELS = $clog2(WIDTH);

    logic s1_valid_q, s2_valid_q;
    logic s1_adv, s2_adv, s1_load, s2_load;

    assign s2_adv       = ~s2_valid_q | bus.out_ready;
    assign s1_adv       = ~s1_valid_q | s2_adv;
    assign s1_load      = s1_adv & bus.in_valid;
    assign s2_load      = s2_adv & s1_valid_q;
    assign bus.in_ready = s1_adv;

    // Borrow-in folded into bit 0 (grey cell), so the tree only spans WIDTH bits.
    logic [WIDTH-1:0] x_d, g_base, p_base;
    always_comb begin
        x_d       = bus.in_a ^ bus.in_b;
        g_base    = ~bus.in_a & bus.in_b;
        p_base    = ~x_d;
        g_base[0] = g_base[0] | (p_base[0] & bus.in_bin);
        p_base[0] = 1'b0;
    end

    logic [WIDTH-1:0] g_s1_d, p_s1_d, g_s1_q, p_s1_q, x_s1_q;
    logic             a_msb_s1_q, b_msb_s1_q, bin_s1_q;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        logic [WIDTH-1:0] g_in, p_in, g_out, p_out;
        if (k == SPLIT) begin : g_src_reg
            assign g_in = g_s1_q;
            assign p_in = p_s1_q;
        end else if (k == 0) begin : g_src_base
            assign g_in = g_base;
            assign p_in = p_base;
        end else begin : g_src_prev
            assign g_in = g_lvl[k-1].g_out;
            assign p_in = g_lvl[k-1].p_out;
        end
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (((i >> k) & 1) == 1) begin : g_cell
                localparam int J = ((i >> k) << k) - 1;
                assign g_out[i] = g_in[i] | (p_in[i] & g_in[J]);
                assign p_out[i] = p_in[i] & p_in[J];
            end else begin : g_pass
                assign g_out[i] = g_in[i];
                assign p_out[i] = p_in[i];
            end
        end
    end

    logic [WIDTH-1:0] g_fin;
    logic             unused_p;
    if (SPLIT == 0) begin : g_s1_none
        assign g_s1_d = g_base;
        assign p_s1_d = p_base;
    end else begin : g_s1_tree
        assign g_s1_d = g_lvl[SPLIT-1].g_out;
        assign p_s1_d = g_lvl[SPLIT-1].p_out;
    end
    if (SPLIT >= LEVELS) begin : g_fin_reg
        assign g_fin    = g_s1_q;
        assign unused_p = &p_s1_q;
    end else begin : g_fin_tree
        assign g_fin    = g_lvl[LEVELS-1].g_out;
        assign unused_p = &g_lvl[LEVELS-1].p_out;
    end

    logic [WIDTH-1:0] diff_d, diff_q;
    logic             borrow_d, zero_d, neg_d, ovf_d;
    logic             borrow_q, zero_q, neg_q, ovf_q;

    always_comb begin
        diff_d   = x_s1_q ^ {g_fin[WIDTH-2:0], bin_s1_q};
        borrow_d = g_fin[WIDTH-1];
        zero_d   = (diff_d == '0);
        neg_d    = diff_d[WIDTH-1];
        ovf_d    = (a_msb_s1_q ^ b_msb_s1_q) & (diff_d[WIDTH-1] ^ a_msb_s1_q);
    end

    always_ff @(posedge clk) begin
        if (s1_load) begin
            g_s1_q     <= g_s1_d;
            p_s1_q     <= p_s1_d;
            x_s1_q     <= x_d;
            a_msb_s1_q <= bus.in_a[WIDTH-1];
            b_msb_s1_q <= bus.in_b[WIDTH-1];
            bin_s1_q   <= bus.in_bin;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (s1_adv) s1_valid_q <= bus.in_valid;
            if (s2_adv) s2_valid_q <= s1_valid_q;
            if (s2_load) begin
                diff_q   <= diff_d;
                borrow_q <= borrow_d;
                zero_q   <= zero_d;
                neg_q    <= neg_d;
                ovf_q    <= ovf_d;
            end
        end
    end

    assign bus.out_valid  = s2_valid_q;
    assign bus.out_diff   = diff_q;
    assign bus.out_borrow = borrow_q;
    assign bus.out_zero   = zero_q;
    assign bus.out_neg    = neg_q;
    assign bus.out_ovf    = ovf_q;
endmodule

// File: tb/tb_sklansky_subtractor_pipe.sv
// Random and directed stimulus against an arithmetic reference model with an in-order scoreboard.
module tb_sklansky_subtractor_pipe;
    localparam int unsigned WIDTH = 32;
    localparam longint SMAX = (longint'(1) <<< (WIDTH - 1)) - 1;
    localparam longint SMIN = -SMAX - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sklansky_subtractor_pipe_if #(.WIDTH(WIDTH)) bus ();

    sklansky_subtractor_pipe #(.WIDTH(WIDTH), .SPLIT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [WIDTH+3:0] exp_q[$];
    logic             stall_prev;
    logic [WIDTH+3:0] stall_val;
    logic [WIDTH+3:0] obs;
    assign obs = {bus.out_ovf, bus.out_neg, bus.out_zero, bus.out_borrow, bus.out_diff};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH+3:0] pk(input logic ovf, input logic neg, input logic zero,
                                            input logic borrow, input logic [WIDTH-1:0] diff);
        return {ovf, neg, zero, borrow, diff};
    endfunction

    function automatic logic [WIDTH+3:0] ref_result(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b, input logic bin);
        logic [WIDTH:0] wide;
        longint         sd;
        logic           ovf;
        wide = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
        sd   = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        ovf  = (sd > SMAX) || (sd < SMIN);
        return {ovf, wide[WIDTH-1], (wide[WIDTH-1:0] == '0), wide[WIDTH], wide[WIDTH-1:0]};
    endfunction

    task automatic step(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bin, input logic rdy);
        logic [WIDTH+3:0] exp;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_bin    = bin;
        bus.out_ready = rdy;
        #1;
        if (stall_prev) begin
            check_eq("hold_valid", bus.out_valid, 1'b1);
            check_eq("hold_data", obs, stall_val);
        end
        // Two results in flight fill both stages; a stalled sink must then back-pressure.
        check_eq("in_ready", bus.in_ready, !(exp_q.size() == 2 && !rdy));
        if (bus.out_valid && rdy) begin
            check_eq("out_has_expect", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                check_eq("result", obs, exp);
            end
        end
        if (v && bus.in_ready) exp_q.push_back(ref_result(a, b, bin));
        stall_prev = bus.out_valid && !rdy;
        stall_val  = obs;
    endtask

    task automatic do_reset(input logic busy_inputs);
        @(negedge clk);
        rst           = 1'b1;
        bus.in_valid  = busy_inputs;
        bus.in_a      = $urandom;
        bus.in_b      = $urandom;
        bus.in_bin    = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_outs", obs, '0);
        check_eq("rst_in_ready", bus.in_ready, 1'b1);
        exp_q.delete();
        stall_prev = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic bin, input logic [WIDTH+3:0] exp);
        step(1'b1, a, b, bin, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        check_eq({tag, "_lat1"}, bus.out_valid, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        check_eq({tag, "_lat2"}, bus.out_valid, 1'b1);
        check_eq(tag, obs, exp);
    endtask

    task automatic drain(input string tag);
        repeat (6) step(1'b0, '0, '0, 1'b0, 1'b1);
        check_eq(tag, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] a, b;
        logic             v, rdy;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_bin    = 1'b0;
        bus.out_ready = 1'b0;
        stall_prev    = 1'b0;
        stall_val     = '0;

        do_reset(1'b0);

        directed("t1", 32'h5, 32'h3, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 32'h2));
        directed("t2_neg", 32'h0, 32'h1, 1'b0, pk(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF));
        directed("t2_zero", 32'h1234_5678, 32'h1234_5678, 1'b0, pk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
        directed("t3_ovf", 32'h8000_0000, 32'h1, 1'b0, pk(1'b1, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF));
        directed("t3_bin", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, pk(1'b0, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF));

        for (int i = 0; i < 8; i++) begin
            step(1'b1, $urandom, $urandom, 1'($urandom), 1'b1);
            if (i >= 2) check_eq("t4_stream", bus.out_valid, 1'b1);
        end
        repeat (2) begin
            step(1'b0, '0, '0, 1'b0, 1'b1);
            check_eq("t4_tail", bus.out_valid, 1'b1);
        end
        repeat (4) step(1'b1, $urandom, $urandom, 1'($urandom), 1'b1);
        repeat (3) step(1'b1, $urandom, $urandom, 1'($urandom), 1'b0);
        repeat (4) step(1'b1, $urandom, $urandom, 1'($urandom), 1'b1);
        drain("t4_drain");

        step(1'b1, $urandom, $urandom, 1'b0, 1'b0);
        step(1'b1, $urandom, $urandom, 1'b1, 1'b0);
        step(1'b1, $urandom, $urandom, 1'b0, 1'b0);
        do_reset(1'b1);
        directed("t5_after", 32'd100, 32'd58, 1'b1, pk(1'b0, 1'b0, 1'b0, 1'b0, 32'd41));

        for (int i = 0; i < 10000; i++) begin
            a   = $urandom;
            b   = $urandom;
            case ($urandom_range(0, 7))
                0: b = a;
                1: a = '0;
                2: b = '1;
                3: a = {1'b1, {(WIDTH-1){1'b0}}};
                default: ;
            endcase
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            step(v, a, b, 1'($urandom), rdy);
        end
        drain("t6_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
